// File: rtl/phold_mem_arbiter.sv
// Round-robin arbiter sharing one MC request port among NC phold cores.
// Optional ARB_STATS_EN adds saturating grant/stall counters.
module phold_mem_arbiter #(
  parameter int NC              = 4,
  parameter int NCB             = 2,
  parameter int MC_RTNCTL_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NC-1:0]                core_rq_vld,
  input  logic [3*NC-1:0]              core_rq_cmd,
  input  logic [4*NC-1:0]              core_rq_scmd,
  input  logic [48*NC-1:0]             core_rq_vadr,
  input  logic [2*NC-1:0]              core_rq_size,
  input  logic [MC_RTNCTL_WIDTH*NC-1:0] core_rq_rtnctl,
  input  logic [64*NC-1:0]             core_rq_data,
  output logic [NC-1:0]                core_mem_gnt,
  output logic                         mc_rq_vld,
  output logic [2:0]                   mc_rq_cmd,
  output logic [3:0]                   mc_rq_scmd,
  output logic [47:0]                  mc_rq_vadr,
  output logic [1:0]                   mc_rq_size,
  output logic [MC_RTNCTL_WIDTH-1:0]   mc_rq_rtnctl,
  output logic [63:0]                  mc_rq_data,
  output logic                         mc_rq_flush,
  input  logic                         mc_rq_stall,
  input  logic                         mc_rs_vld,
  input  logic [2:0]                   mc_rs_cmd,
  input  logic [3:0]                   mc_rs_scmd,
  input  logic [MC_RTNCTL_WIDTH-1:0]   mc_rs_rtnctl,
  input  logic [63:0]                  mc_rs_data,
  output logic                         mc_rs_stall,
  output logic                         core_rs_vld,
  output logic [2:0]                   core_rs_cmd,
  output logic [3:0]                   core_rs_scmd,
  output logic [MC_RTNCTL_WIDTH-1:0]   core_rs_rtnctl,
  output logic [63:0]                  core_rs_data
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]                  grant_count,
  output logic [31:0]                  stall_cycles
`endif
);

  localparam int RW = MC_RTNCTL_WIDTH;

  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   w_load;

  logic [NCB-1:0] r_rr_ptr;
  logic [NCB-1:0] w_rr_nxt;
  logic [NCB-1:0] w_hi;
  logic [NCB-1:0] w_lo;
  logic           w_hi_found;
  logic [NCB-1:0] w_win;

  logic [NC-1:0]  w_gnt;
  logic [2:0]     w_cmd;
  logic [3:0]     w_scmd;
  logic [47:0]    w_vadr;
  logic [1:0]     w_size;
  logic [RW-1:0]  w_rtnctl;
  logic [63:0]    w_data;

  logic [NC-1:0]  r_gnt;
  logic           r_vld;
  logic [2:0]     r_cmd;
  logic [3:0]     r_scmd;
  logic [47:0]    r_vadr;
  logic [1:0]     r_size;
  logic [RW-1:0]  r_rtnctl;
  logic [63:0]    r_data;

  logic           r_rs_vld;
  logic [2:0]     r_rs_cmd;
  logic [3:0]     r_rs_scmd;
  logic [RW-1:0]  r_rs_rtnctl;
  logic [63:0]    r_rs_data;

  // Lowest requester at/above the pointer wins, else lowest overall
  always_comb begin
    w_hi       = '0;
    w_lo       = '0;
    w_hi_found = 1'b0;
    for (int i = NC - 1; i >= 0; i--) begin
      if (core_rq_vld[i]) begin
        w_lo = NCB'(i);
        if (NCB'(i) >= r_rr_ptr) begin
          w_hi       = NCB'(i);
          w_hi_found = 1'b1;
        end
      end
    end
    w_win = w_hi_found ? w_hi : w_lo;
  end

  assign w_rr_nxt = (w_win == NCB'(NC - 1)) ? '0
                                            : w_win + 1'b1;

  always_comb begin
    w_gnt    = '0;
    w_cmd    = '0;
    w_scmd   = '0;
    w_vadr   = '0;
    w_size   = '0;
    w_rtnctl = '0;
    w_data   = '0;
    for (int i = 0; i < NC; i++) begin
      if (NCB'(i) == w_win) begin
        w_gnt[i] = 1'b1;
        w_cmd    = core_rq_cmd[3*i +: 3];
        w_scmd   = core_rq_scmd[4*i +: 4];
        w_vadr   = core_rq_vadr[48*i +: 48];
        w_size   = core_rq_size[2*i +: 2];
        w_rtnctl = core_rq_rtnctl[RW*i +: RW];
        w_data   = core_rq_data[64*i +: 64];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ARB;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    unique case (r_state)
      ARB: begin
        if (|core_rq_vld && !mc_rq_stall) begin
          w_load = 1'b1;
          w_next = HOLD;
        end
      end
      HOLD:    w_next = ARB;
      default: w_next = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
      r_gnt    <= '0;
      r_vld    <= 1'b0;
      r_cmd    <= '0;
      r_scmd   <= '0;
      r_vadr   <= '0;
      r_size   <= '0;
      r_rtnctl <= '0;
      r_data   <= '0;
    end else begin
      r_vld <= w_load;
      r_gnt <= w_load ? w_gnt : '0;
      if (w_load) begin
        r_rr_ptr <= w_rr_nxt;
        r_cmd    <= w_cmd;
        r_scmd   <= w_scmd;
        r_vadr   <= w_vadr;
        r_size   <= w_size;
        r_rtnctl <= w_rtnctl;
        r_data   <= w_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rs_vld    <= 1'b0;
      r_rs_cmd    <= '0;
      r_rs_scmd   <= '0;
      r_rs_rtnctl <= '0;
      r_rs_data   <= '0;
    end else begin
      r_rs_vld    <= mc_rs_vld;
      r_rs_cmd    <= mc_rs_cmd;
      r_rs_scmd   <= mc_rs_scmd;
      r_rs_rtnctl <= mc_rs_rtnctl;
      r_rs_data   <= mc_rs_data;
    end
  end

  assign core_mem_gnt   = r_gnt;
  assign mc_rq_vld      = r_vld;
  assign mc_rq_cmd      = r_cmd;
  assign mc_rq_scmd     = r_scmd;
  assign mc_rq_vadr     = r_vadr;
  assign mc_rq_size     = r_size;
  assign mc_rq_rtnctl   = r_rtnctl;
  assign mc_rq_data     = r_data;
  assign mc_rq_flush    = 1'b0;
  assign mc_rs_stall    = 1'b0;
  assign core_rs_vld    = r_rs_vld;
  assign core_rs_cmd    = r_rs_cmd;
  assign core_rs_scmd   = r_rs_scmd;
  assign core_rs_rtnctl = r_rs_rtnctl;
  assign core_rs_data   = r_rs_data;

`ifdef ARB_STATS_EN
  logic [31:0] r_grant_cnt;
  logic [31:0] r_stall_cnt;
  logic        w_stall_cyc;

  assign w_stall_cyc = (r_state == ARB) && |core_rq_vld
                       && mc_rq_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_load && r_grant_cnt != '1)
        r_grant_cnt <= r_grant_cnt + 32'd1;
      if (w_stall_cyc && r_stall_cnt != '1)
        r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign grant_count  = r_grant_cnt;
  assign stall_cycles = r_stall_cnt;
`endif

endmodule

// File: tb/tb_phold_mem_arbiter.sv
// Scoreboard bench for phold_mem_arbiter against a queue-based model.
// Stats counters are checked when ARB_STATS_EN is defined.
module tb_phold_mem_arbiter;
  localparam int NC  = 4;
  localparam int NCB = 2;
  localparam int RW  = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_n = 1'b1;
  logic [NC-1:0]       core_rq_vld = '0;
  logic [3*NC-1:0]     core_rq_cmd = '0;
  logic [4*NC-1:0]     core_rq_scmd = '0;
  logic [48*NC-1:0]    core_rq_vadr = '0;
  logic [2*NC-1:0]     core_rq_size = '0;
  logic [RW*NC-1:0]    core_rq_rtnctl = '0;
  logic [64*NC-1:0]    core_rq_data = '0;
  logic [NC-1:0]       core_mem_gnt;
  logic                mc_rq_vld;
  logic [2:0]          mc_rq_cmd;
  logic [3:0]          mc_rq_scmd;
  logic [47:0]         mc_rq_vadr;
  logic [1:0]          mc_rq_size;
  logic [RW-1:0]       mc_rq_rtnctl;
  logic [63:0]         mc_rq_data;
  logic                mc_rq_flush;
  logic                mc_rq_stall = 1'b0;
  logic                mc_rs_vld = 1'b0;
  logic [2:0]          mc_rs_cmd = '0;
  logic [3:0]          mc_rs_scmd = '0;
  logic [RW-1:0]       mc_rs_rtnctl = '0;
  logic [63:0]         mc_rs_data = '0;
  logic                mc_rs_stall;
  logic                core_rs_vld;
  logic [2:0]          core_rs_cmd;
  logic [3:0]          core_rs_scmd;
  logic [RW-1:0]       core_rs_rtnctl;
  logic [63:0]         core_rs_data;
`ifdef ARB_STATS_EN
  logic [31:0]         grant_count;
  logic [31:0]         stall_cycles;
  logic [31:0]         g3_cnt;
  logic [31:0]         s3_cnt;
`endif

  phold_mem_arbiter #(.NC(NC), .NCB(NCB), .MC_RTNCTL_WIDTH(RW)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_rq_vld(core_rq_vld), .core_rq_cmd(core_rq_cmd),
    .core_rq_scmd(core_rq_scmd), .core_rq_vadr(core_rq_vadr),
    .core_rq_size(core_rq_size), .core_rq_rtnctl(core_rq_rtnctl),
    .core_rq_data(core_rq_data), .core_mem_gnt(core_mem_gnt),
    .mc_rq_vld(mc_rq_vld), .mc_rq_cmd(mc_rq_cmd),
    .mc_rq_scmd(mc_rq_scmd), .mc_rq_vadr(mc_rq_vadr),
    .mc_rq_size(mc_rq_size), .mc_rq_rtnctl(mc_rq_rtnctl),
    .mc_rq_data(mc_rq_data), .mc_rq_flush(mc_rq_flush),
    .mc_rq_stall(mc_rq_stall), .mc_rs_vld(mc_rs_vld),
    .mc_rs_cmd(mc_rs_cmd), .mc_rs_scmd(mc_rs_scmd),
    .mc_rs_rtnctl(mc_rs_rtnctl), .mc_rs_data(mc_rs_data),
    .mc_rs_stall(mc_rs_stall), .core_rs_vld(core_rs_vld),
    .core_rs_cmd(core_rs_cmd), .core_rs_scmd(core_rs_scmd),
    .core_rs_rtnctl(core_rs_rtnctl), .core_rs_data(core_rs_data)
`ifdef ARB_STATS_EN
    , .grant_count(grant_count), .stall_cycles(stall_cycles)
`endif
  );

  // Three-core instance: cores 0 and 2 request forever
  logic           rst3_n = 1'b1;
  logic [2:0]     v3 = 3'b101;
  logic [2:0]     gnt3;
  logic           o3_vld, o3_flush, o3_rs_stall, o3_rs_vld;
  logic [2:0]     o3_cmd, o3_rs_cmd;
  logic [3:0]     o3_scmd, o3_rs_scmd;
  logic [47:0]    o3_vadr;
  logic [1:0]     o3_size;
  logic [RW-1:0]  o3_rtn, o3_rs_rtn;
  logic [63:0]    o3_data, o3_rs_data;
  logic [3*3-1:0] z3_cmd = '0;
  logic [4*3-1:0] z3_scmd = '0;
  logic [48*3-1:0] z3_vadr = '0;
  logic [2*3-1:0] z3_size = '0;
  logic [RW*3-1:0] z3_rtn = '0;
  logic [64*3-1:0] z3_data = '0;

  phold_mem_arbiter #(.NC(3), .NCB(2), .MC_RTNCTL_WIDTH(RW)) u3 (
    .clk(clk), .rst_n(rst3_n),
    .core_rq_vld(v3), .core_rq_cmd(z3_cmd),
    .core_rq_scmd(z3_scmd), .core_rq_vadr(z3_vadr),
    .core_rq_size(z3_size), .core_rq_rtnctl(z3_rtn),
    .core_rq_data(z3_data), .core_mem_gnt(gnt3),
    .mc_rq_vld(o3_vld), .mc_rq_cmd(o3_cmd),
    .mc_rq_scmd(o3_scmd), .mc_rq_vadr(o3_vadr),
    .mc_rq_size(o3_size), .mc_rq_rtnctl(o3_rtn),
    .mc_rq_data(o3_data), .mc_rq_flush(o3_flush),
    .mc_rq_stall(1'b0), .mc_rs_vld(1'b0),
    .mc_rs_cmd(3'd0), .mc_rs_scmd(4'd0),
    .mc_rs_rtnctl(32'd0), .mc_rs_data(64'd0),
    .mc_rs_stall(o3_rs_stall), .core_rs_vld(o3_rs_vld),
    .core_rs_cmd(o3_rs_cmd), .core_rs_scmd(o3_rs_scmd),
    .core_rs_rtnctl(o3_rs_rtn), .core_rs_data(o3_rs_data)
`ifdef ARB_STATS_EN
    , .grant_count(g3_cnt), .stall_cycles(s3_cnt)
`endif
  );

  typedef struct {
    int          tag;
    logic [NC-1:0] gnt;
    logic [2:0]  cmd;
    logic [3:0]  scmd;
    logic [47:0] vadr;
    logic [1:0]  size;
    logic [RW-1:0] rtn;
    logic [63:0] data;
  } rq_t;

  typedef struct {
    int          tag;
    logic [2:0]  cmd;
    logic [3:0]  scmd;
    logic [RW-1:0] rtn;
    logic [63:0] data;
  } rs_t;

  rq_t rq_q[$];
  rs_t rs_q[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  function automatic void chk(string nm, logic [63:0] act,
                              logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endfunction

  // Reference model: pointer, hold flag, counters
  int m_ptr    = 0;
  bit m_hold   = 0;
  int m_grants = 0;
  int m_stall  = 0;

  task automatic step();
    int  w;
    rq_t e;
    if (mc_rs_vld)
      rs_q.push_back('{cyc + 1, mc_rs_cmd, mc_rs_scmd,
                       mc_rs_rtnctl, mc_rs_data});
    if (m_hold) begin
      m_hold = 0;
    end else if (core_rq_vld != '0) begin
      if (mc_rq_stall) begin
        m_stall++;
      end else begin
        w = -1;
        for (int k = 0; k < NC; k++)
          if (w < 0 && core_rq_vld[(m_ptr + k) % NC])
            w = (m_ptr + k) % NC;
        e.tag  = cyc + 1;
        e.gnt  = '0;
        e.gnt[w] = 1'b1;
        e.cmd  = core_rq_cmd[3*w +: 3];
        e.scmd = core_rq_scmd[4*w +: 4];
        e.vadr = core_rq_vadr[48*w +: 48];
        e.size = core_rq_size[2*w +: 2];
        e.rtn  = core_rq_rtnctl[RW*w +: RW];
        e.data = core_rq_data[64*w +: 64];
        rq_q.push_back(e);
        m_ptr  = (w + 1) % NC;
        m_hold = 1;
        m_grants++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_fields();
    for (int i = 0; i < NC; i++) begin
      core_rq_cmd[3*i +: 3]     = 3'($urandom);
      core_rq_scmd[4*i +: 4]    = 4'($urandom);
      core_rq_vadr[48*i +: 48]  = 48'({$urandom, $urandom});
      core_rq_size[2*i +: 2]    = 2'($urandom);
      core_rq_rtnctl[RW*i +: RW] = $urandom;
      core_rq_data[64*i +: 64]  = {$urandom, $urandom};
    end
    mc_rs_cmd    = 3'($urandom);
    mc_rs_scmd   = 4'($urandom);
    mc_rs_rtnctl = $urandom;
    mc_rs_data   = {$urandom, $urandom};
  endtask

  task automatic do_reset();
    core_rq_vld = '0;
    mc_rs_vld   = 1'b0;
    mc_rq_stall = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_mc_rq_vld", mc_rq_vld, 0);
    chk("rst_gnt", core_mem_gnt, 0);
    chk("rst_rs_vld", core_rs_vld, 0);
    chk("rst_vadr", mc_rq_vadr, 0);
    chk("rst_flush", mc_rq_flush, 0);
    chk("rst_rs_stall", mc_rs_stall, 0);
    rq_q.delete();
    rs_q.delete();
    m_ptr = 0;
    m_hold = 0;
    m_grants = 0;
    m_stall = 0;
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops expectations whenever the DUT presents a transfer
  logic [47:0] last_vadr;
  logic [63:0] last_data;
  logic        prev_vld;
  always @(negedge clk) begin
    rq_t e;
    rs_t r;
    if (!rst_n) begin
      last_vadr = '0;
      last_data = '0;
      prev_vld  = 1'b0;
    end else begin
      chk("back_to_back", prev_vld & mc_rq_vld, 0);
      if (mc_rq_vld) begin
        if (rq_q.size() > 0 && rq_q[0].tag == cyc) begin
          e = rq_q.pop_front();
          chk("gnt", core_mem_gnt, e.gnt);
          chk("cmd", mc_rq_cmd, e.cmd);
          chk("scmd", mc_rq_scmd, e.scmd);
          chk("vadr", mc_rq_vadr, e.vadr);
          chk("size", mc_rq_size, e.size);
          chk("rtnctl", mc_rq_rtnctl, e.rtn);
          chk("data", mc_rq_data, e.data);
          last_vadr = e.vadr;
          last_data = e.data;
        end else begin
          chk("rq_unexpected", mc_rq_vld, 0);
        end
      end else begin
        chk("gnt_idle", core_mem_gnt, 0);
        chk("hold_vadr", mc_rq_vadr, last_vadr);
        chk("hold_data", mc_rq_data, last_data);
        if (rq_q.size() > 0 && rq_q[0].tag <= cyc) begin
          void'(rq_q.pop_front());
          chk("rq_missing", mc_rq_vld, 1);
        end
      end
      prev_vld = mc_rq_vld;
      if (core_rs_vld) begin
        if (rs_q.size() > 0 && rs_q[0].tag == cyc) begin
          r = rs_q.pop_front();
          chk("rs_cmd", core_rs_cmd, r.cmd);
          chk("rs_scmd", core_rs_scmd, r.scmd);
          chk("rs_rtnctl", core_rs_rtnctl, r.rtn);
          chk("rs_data", core_rs_data, r.data);
        end else begin
          chk("rs_unexpected", core_rs_vld, 0);
        end
      end else if (rs_q.size() > 0 && rs_q[0].tag <= cyc) begin
        void'(rs_q.pop_front());
        chk("rs_missing", core_rs_vld, 1);
      end
    end
  end

  // NC=3 checker: grants alternate 0,2,0,2
  logic [2:0] exp3 = 3'b001;
  int         n3   = 0;
  always @(negedge clk) begin
    if (rst3_n && gnt3 != '0) begin
      chk("nc3_gnt", gnt3, exp3);
      exp3 = (exp3 == 3'b001) ? 3'b100 : 3'b001;
      n3++;
    end
  end

  initial begin
`ifdef ARB_STATS_EN
    logic [31:0] s0;
`endif
    #1;
    rst3_n = 1'b0;
    do_reset();
    rst3_n = 1'b1;

    // Single request from core 2
    rand_fields();
    core_rq_vld = 4'b0100;
    core_rq_cmd[8:6] = 3'd1;
    core_rq_vadr[2*48 +: 48] = 48'h1010;
    step();
    chk("t1_vld", mc_rq_vld, 1);
    chk("t1_vadr", mc_rq_vadr, 48'h1010);
    chk("t1_gnt", core_mem_gnt, 4'b0100);

    // Response arriving while the arbiter holds
    mc_rs_vld    = 1'b1;
    mc_rs_cmd    = 3'd3;
    mc_rs_rtnctl = 32'h3;
    step();
    chk("t1_hold_vld", mc_rq_vld, 0);
    chk("t1_hold_gnt", core_mem_gnt, 0);
    chk("t4_rs_vld", core_rs_vld, 1);
    chk("t4_rs_rtn", core_rs_rtnctl, 32'h3);
    mc_rs_vld   = 1'b0;
    core_rq_vld = '0;
    step();

    // All cores requesting: starts at core 3
    core_rq_vld = '1;
    rand_fields();
    step();
    chk("t2_first_gnt", core_mem_gnt, 4'b1000);
    for (int i = 0; i < 15; i++) begin
      rand_fields();
      step();
    end
    core_rq_vld = '0;
    step();
    step();

    // Core 1 stalled for 5 cycles
`ifdef ARB_STATS_EN
    s0 = stall_cycles;
`endif
    core_rq_vld = 4'b0010;
    mc_rq_stall = 1'b1;
    for (int i = 0; i < 5; i++) step();
`ifdef ARB_STATS_EN
    chk("t3_stall_cycles", stall_cycles - s0, 5);
`endif
    mc_rq_stall = 1'b0;
    step();
    chk("t3_gnt", core_mem_gnt, 4'b0010);
    core_rq_vld = '0;
    step();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rand_fields();
      core_rq_vld = NC'($urandom);
      mc_rq_stall = ($urandom_range(0, 3) == 0);
      mc_rs_vld   = 1'($urandom);
      step();
    end
    mc_rs_vld   = 1'b0;
    mc_rq_stall = 1'b0;

    // Reset while a request is on the MC port
    core_rq_vld = '1;
    for (int i = 0; i < 4; i++)
      if (!mc_rq_vld) step();
    chk("t5_pre_vld", mc_rq_vld, 1);
    do_reset();
    core_rq_vld = '1;
    rand_fields();
    step();
    chk("t5_post_gnt", core_mem_gnt, 4'b0001);
    core_rq_vld = '0;
    step();
    step();
    step();

    chk("rq_drain", rq_q.size(), 0);
    chk("rs_drain", rs_q.size(), 0);
    chk("nc3_grants_seen", n3 >= 8, 1);
`ifdef ARB_STATS_EN
    chk("grant_count", grant_count, m_grants);
    chk("stall_total", stall_cycles, m_stall);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
